// File: rtl/eth_cmd_regbank.sv
// eth_cmd_regbank: control register bank driven by the parsed Ethernet command stream.
//
// Commands (cmdvalid/address/cmd_data) write a bank of NUM_REGS 32-bit registers
// (address < NUM_REGS) or read them back (address 0x80+n). Any other address is
// invalid. Each write pulses wr_pulse[n] for one cycle. Registers flagged in
// SELFCLR_MASK return to zero one cycle after being written.
//
// Build option ETH_CMD_ACK_EN: when defined, every command produces an 8-byte
// reply frame (55 A5 addr d3 d2 d1 d0 F0) pushed into the TX byte FIFO through a
// sender plus a 1-deep pending buffer. Replies that find both occupied are dropped
// and counted. When undefined, the reply path is absent, the TX outputs are tied
// to zero and read commands have no effect.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   cmdvalid, address, cmd_data   command strobe and payload
//   regs_out                  flattened bank, register n at [32n+31:32n]
//   wr_pulse                  one-cycle write strobe per register
//   tx_full, tx_wr_en, tx_din TX FIFO interface (tx_wr_en is combinational on tx_full)
//   busy                      reply frame being sent or pending
//   err_cnt, drop_cnt         saturating invalid-command and dropped-reply counts
module eth_cmd_regbank #(
  parameter int unsigned NUM_REGS     = 16,
  parameter logic [63:0] SELFCLR_MASK = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmdvalid,
  input  logic [7:0]               address,
  input  logic [31:0]              cmd_data,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_pulse,
  input  logic                     tx_full,
  output logic                     tx_wr_en,
  output logic [7:0]               tx_din,
  output logic                     busy,
  output logic [7:0]               err_cnt,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 8;

  // Address decode
  logic is_wr_c, is_rd_c, is_inv_c;
  assign is_wr_c  = (address < AW'(NUM_REGS));
  assign is_rd_c  = address[7] && (address[6:0] < 7'(NUM_REGS));
  assign is_inv_c = !is_wr_c && !is_rd_c;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [CW-1:0]       err_cnt_q, err_cnt_d;

  // Register bank: a write in the same cycle as a pending self-clear wins
  always_comb begin
    for (int unsigned n = 0; n < NUM_REGS; n++) begin
      regs_d[n]     = regs_q[n];
      wr_pulse_d[n] = 1'b0;
      if (wr_pulse_q[n] && SELFCLR_MASK[n]) regs_d[n] = '0;
      if (cmdvalid && is_wr_c && (address == AW'(n))) begin
        regs_d[n]     = cmd_data;
        wr_pulse_d[n] = 1'b1;
      end
    end
    err_cnt_d = err_cnt_q;
    if (cmdvalid && is_inv_c && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CW'(1);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DW +: DW] = regs_q[g];
  end
  assign wr_pulse = wr_pulse_q;
  assign err_cnt  = err_cnt_q;

`ifdef ETH_CMD_ACK_EN
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [AW-1:0] snd_addr_q, snd_addr_d, pend_addr_q, pend_addr_d;
  logic [DW-1:0] snd_data_q, snd_data_d, pend_data_q, pend_data_d;
  logic          pend_v_q, pend_v_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [DW-1:0] rd_data_c, rply_data_c;
  logic          last_wr_c, pend_free_c;

  always_comb begin
    rd_data_c = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++)
      if (address[6:0] == 7'(n)) rd_data_c = regs_q[n];
  end

  assign rply_data_c = is_wr_c ? cmd_data : (is_rd_c ? rd_data_c : 32'hEEEE_EEEE);
  assign tx_wr_en    = (state_q == S_SEND) && !tx_full;
  assign last_wr_c   = tx_wr_en && (idx_q == 3'd7);
  // Pending slot is vacated this cycle, so a new entry can take it without a drop
  assign pend_free_c = pend_v_q && ((state_q == S_IDLE) || last_wr_c);

  always_comb begin
    case (idx_q)
      3'd0:    tx_din = 8'h55;
      3'd1:    tx_din = 8'hA5;
      3'd2:    tx_din = snd_addr_q;
      3'd3:    tx_din = snd_data_q[31:24];
      3'd4:    tx_din = snd_data_q[23:16];
      3'd5:    tx_din = snd_data_q[15:8];
      3'd6:    tx_din = snd_data_q[7:0];
      default: tx_din = 8'hF0;
    endcase
  end

  // Sender / pending-buffer next state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snd_addr_d  = snd_addr_q;
    snd_data_d  = snd_data_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    drop_cnt_d  = drop_cnt_q;

    if (state_q == S_IDLE) begin
      if (pend_v_q) begin
        state_d    = S_SEND;
        idx_d      = 3'd0;
        snd_addr_d = pend_addr_q;
        snd_data_d = pend_data_q;
        pend_v_d   = 1'b0;
      end
    end else if (tx_wr_en) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        if (pend_v_q) begin
          snd_addr_d = pend_addr_q;
          snd_data_d = pend_data_q;
          pend_v_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    end

    if (cmdvalid) begin
      if ((state_q == S_IDLE) && !pend_v_q) begin
        state_d    = S_SEND;
        idx_d      = 3'd0;
        snd_addr_d = address;
        snd_data_d = rply_data_c;
      end else if (!pend_v_q || pend_free_c) begin
        pend_v_d    = 1'b1;
        pend_addr_d = address;
        pend_data_d = rply_data_c;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CW'(1);
      end
    end
  end

  assign busy     = (state_q != S_IDLE) || pend_v_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign tx_wr_en       = 1'b0;
  assign tx_din         = '0;
  assign busy           = 1'b0;
  assign drop_cnt       = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
      wr_pulse_q  <= '0;
      err_cnt_q   <= '0;
`ifdef ETH_CMD_ACK_EN
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      snd_addr_q  <= '0;
      snd_data_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      drop_cnt_q  <= '0;
`endif
    end else begin
      for (int unsigned n = 0; n < NUM_REGS; n++) regs_q[n] <= regs_d[n];
      wr_pulse_q  <= wr_pulse_d;
      err_cnt_q   <= err_cnt_d;
`ifdef ETH_CMD_ACK_EN
      state_q     <= state_d;
      idx_q       <= idx_d;
      snd_addr_q  <= snd_addr_d;
      snd_data_q  <= snd_data_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_cmd_regbank.sv
// Self-checking bench for eth_cmd_regbank: directed cases plus random traffic
// compared against a frame-level reference model (register array, reply byte
// queue, occupancy count of sender + pending buffer).
module tb_eth_cmd_regbank;

  localparam int unsigned NR   = 16;
  localparam logic [63:0] MASK = 64'h0000_0000_0000_0021;
`ifdef ETH_CMD_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmdvalid;
  logic [7:0]        address;
  logic [31:0]       cmd_data;
  logic [NR*32-1:0]  regs_out;
  logic [NR-1:0]     wr_pulse;
  logic              tx_full;
  logic              tx_wr_en;
  logic [7:0]        tx_din;
  logic              busy;
  logic [7:0]        err_cnt;
  logic [7:0]        drop_cnt;

  eth_cmd_regbank #(.NUM_REGS(NR), .SELFCLR_MASK(MASK)) dut (
    .clk(clk), .reset_n(reset_n), .cmdvalid(cmdvalid), .address(address),
    .cmd_data(cmd_data), .regs_out(regs_out), .wr_pulse(wr_pulse),
    .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_din(tx_din), .busy(busy),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_reg [NR];
  logic [NR-1:0] m_pulse;
  int          m_err, m_drop;
  int          m_acc, m_bytes;
  logic [7:0]  m_q [$];
  int          n_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < NR; n++) m_reg[n] = '0;
    m_pulse = '0; m_err = 0; m_drop = 0; m_acc = 0; m_bytes = 0;
    m_q.delete();
  endtask

  task automatic check_bank(input string tag);
    for (int n = 0; n < NR; n++)
      check($sformatf("%s_reg%0d", tag, n), 64'(regs_out[n*32 +: 32]), 64'(m_reg[n]));
    check({tag, "_pulse"}, 64'(wr_pulse), 64'(m_pulse));
    check({tag, "_err"}, 64'(err_cnt), 64'(m_err));
    check({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
    check({tag, "_busy"}, 64'(busy), 64'(ACK && (m_acc - m_bytes / 8) > 0));
  endtask

  // One clock cycle: drive inputs, observe TX in this cycle, predict, check after the edge
  task automatic cyc(input bit cv, input logic [7:0] a, input logic [31:0] d, input bit full);
    logic [31:0] nreg [NR];
    logic [NR-1:0] npulse;
    logic [31:0] rdata;
    int n;
    cmdvalid = cv; address = a; cmd_data = d; tx_full = full;
    #1;
    if (tx_wr_en) begin
      n_wr++;
      if (m_q.size() == 0) check("tx_unexpected", 64'(tx_wr_en), 64'(0));
      else begin
        check("tx_byte", 64'(tx_din), 64'(m_q.pop_front()));
        m_bytes++;
      end
    end
    npulse = '0;
    for (int k = 0; k < NR; k++) nreg[k] = (m_pulse[k] && MASK[k]) ? 32'h0 : m_reg[k];
    if (cv) begin
      if (a < NR) begin
        nreg[a] = d; npulse[a] = 1'b1; rdata = d;
      end else if (a >= 8'h80 && a < 8'h80 + NR) begin
        n = int'(a) - 8'h80;
        rdata = m_reg[n];
      end else begin
        rdata = 32'hEEEE_EEEE;
        if (m_err < 255) m_err++;
      end
      if (ACK) begin
        if (m_acc - m_bytes / 8 < 2) begin
          m_acc++;
          m_q.push_back(8'h55); m_q.push_back(8'hA5); m_q.push_back(a);
          m_q.push_back(rdata[31:24]); m_q.push_back(rdata[23:16]);
          m_q.push_back(rdata[15:8]);  m_q.push_back(rdata[7:0]);
          m_q.push_back(8'hF0);
        end else if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) m_reg[k] = nreg[k];
    m_pulse = npulse;
    check_bank("cyc");
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 8'h00, 32'h0, 1'b0);
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    rand_addr = 8'($urandom_range(0, NR - 1));
      2:       rand_addr = 8'(8'h80 + $urandom_range(0, NR - 1));
      default: rand_addr = 8'($urandom_range(NR, 8'h7F));
    endcase
  endfunction

  int w0;

  initial begin
    reset_n = 1'b0; cmdvalid = 1'b0; address = '0; cmd_data = '0; tx_full = 1'b0;
    n_wr = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_txen", 64'(tx_wr_en), 64'(0));
    check_bank("rst");
    reset_n = 1'b1;

    // Write reg 3, frame emitted on 8 consecutive cycles
    cyc(1'b1, 8'h03, 32'h1234_5678, 1'b0);
    check("wr3_value", 64'(regs_out[127:96]), 64'h1234_5678);
    check("wr3_pulse", 64'(wr_pulse), 64'h0008);
    w0 = n_wr;
    idle(8);
    check("wr3_consec", 64'(n_wr - w0), 64'(ACK ? 8 : 0));
    idle(1);

    // Self-clearing register 0
    cyc(1'b1, 8'h00, 32'hA5A5_A5A5, 1'b0);
    check("sc_set", 64'(regs_out[31:0]), 64'hA5A5_A5A5);
    idle(1);
    check("sc_clear", 64'(regs_out[31:0]), 64'h0);
    idle(8);

    // Readback of reg 3
    cyc(1'b1, 8'h83, 32'hDEAD_BEEF, 1'b0);
    check("rd_noreg", 64'(regs_out[127:96]), 64'h1234_5678);
    check("rd_nopulse", 64'(wr_pulse), 64'h0);
    idle(9);

    // Invalid address
    cyc(1'b1, 8'h40, 32'h0BAD_0BAD, 1'b0);
    check("inv_err", 64'(err_cnt), 64'd1);
    idle(9);

    // Back-pressure: sender + pending hold two frames, third reply dropped
    cyc(1'b1, 8'h01, 32'h1111_1111, 1'b1);
    cyc(1'b1, 8'h02, 32'h2222_2222, 1'b1);
    cyc(1'b1, 8'h04, 32'h4444_4444, 1'b1);
    cyc(1'b0, 8'h00, 32'h0, 1'b1);
    check("bp_stall_din", 64'(tx_din), 64'(ACK ? 8'h55 : 8'h00));
    cyc(1'b0, 8'h00, 32'h0, 1'b1);
    check("bp_drop", 64'(drop_cnt), 64'(ACK ? 1 : 0));
    check("bp_reg4", 64'(regs_out[159:128]), 64'h4444_4444);
    w0 = n_wr;
    idle(16);
    check("bp_16bytes", 64'(n_wr - w0), 64'(ACK ? 16 : 0));
    idle(2);
    check("bp_done", 64'(n_wr - w0), 64'(ACK ? 16 : 0));

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), rand_addr(), $urandom(), ($urandom_range(0, 9) < 3));
    idle(40);
    check("rand_drained", 64'(m_q.size()), 64'(0));

    // Saturating counters
    for (int i = 0; i < 260; i++) cyc(1'b1, 8'hFF, $urandom(), 1'($urandom_range(0, 1)));
    check("err_sat", 64'(err_cnt), 64'hFF);
    idle(40);
    check("sat_drained", 64'(m_q.size()), 64'(0));

    // Reset in the middle of a reply frame
    cyc(1'b1, 8'h03, 32'hCAFE_F00D, 1'b0);
    idle(3);
    reset_n = 1'b0;
    #1;
    check("mr_txen", 64'(tx_wr_en), 64'(0));
    model_clear();
    check_bank("mr");
    @(negedge clk);
    check("mr_txen_edge", 64'(tx_wr_en), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    w0 = n_wr;
    idle(10);
    check("mr_nobytes", 64'(n_wr - w0), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
